// File: rtl/ise_issue_if.sv
// Issue-stage bus: decode handshake, ISE ALU request/response, writeback,
// trap report and performance counters bundled for the ise_issue block.
interface ise_issue_if;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_rs1;
  logic [31:0] dec_rs2;
  logic        flush;

  logic        ise_val;
  logic [5:0]  ise_fn;
  logic [6:0]  ise_imm;
  logic [31:0] ise_in1;
  logic [31:0] ise_in2;
  logic        ise_oval;
  logic [31:0] ise_out;

  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  logic        trap_valid;
  logic [1:0]  trap_cause;
  logic [31:0] trap_instr;
  logic        trap_ack;

  logic [31:0] perf_issued;
  logic [31:0] perf_trap;

  // master: surrounding pipeline / ISE / writeback environment
  modport master (
    output dec_valid, dec_instr, dec_rs1, dec_rs2, flush,
           ise_oval, ise_out, wb_ready, trap_ack,
    input  dec_ready, ise_val, ise_fn, ise_imm, ise_in1, ise_in2,
           wb_valid, wb_rd, wb_data, trap_valid, trap_cause, trap_instr,
           perf_issued, perf_trap
  );

  // slave: the issuer itself
  modport slave (
    input  dec_valid, dec_instr, dec_rs1, dec_rs2, flush,
           ise_oval, ise_out, wb_ready, trap_ack,
    output dec_ready, ise_val, ise_fn, ise_imm, ise_in1, ise_in2,
           wb_valid, wb_rd, wb_data, trap_valid, trap_cause, trap_instr,
           perf_issued, perf_trap
  );
endinterface

// File: rtl/ise_issue.sv
// Custom-instruction issuer: hands custom-0..3 ops to the ISE ALU, writes back
// or traps. Optional perf counters enabled by defining ISE_ISSUE_PERF_EN.
module ise_issue #(
  parameter int unsigned TIMEOUT = 4
) (
  input logic        ise_clk,
  input logic        ise_rst,
  ise_issue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WB, TRAP} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } req_t;

  localparam logic [3:0] CNT_LAST = 4'(TIMEOUT - 1);

  state_t      state;
  logic [3:0]  cnt;
  req_t        req;
  req_t        req_in;

  logic        dec_ready_q;
  logic        ise_val_q;
  logic [5:0]  ise_fn_q;
  logic        wb_valid_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        trap_valid_q;
  logic [1:0]  trap_cause_q;

  logic        is_custom;
  logic [1:0]  cidx;
  logic        accept;

  assign req_in = '{instr: bus.dec_instr, rs1: bus.dec_rs1, rs2: bus.dec_rs2};
  assign accept = bus.dec_valid && dec_ready_q;

  always_comb begin
    is_custom = 1'b1;
    cidx      = 2'd0;
    case (bus.dec_instr[6:0])
      7'b0001011: cidx = 2'd0;
      7'b0101011: cidx = 2'd1;
      7'b1011011: cidx = 2'd2;
      7'b1111011: cidx = 2'd3;
      default:    is_custom = 1'b0;
    endcase
  end

  // Every output is a register written here; dec_ready mirrors state==IDLE.
  always_ff @(posedge ise_clk) begin
    if (!ise_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      req          <= '0;
      dec_ready_q  <= 1'b1;
      ise_val_q    <= 1'b0;
      ise_fn_q     <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      trap_valid_q <= 1'b0;
      trap_cause_q <= '0;
    end else if (bus.flush) begin
      state        <= IDLE;
      cnt          <= '0;
      dec_ready_q  <= 1'b1;
      ise_val_q    <= 1'b0;
      wb_valid_q   <= 1'b0;
      trap_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req         <= req_in;
            dec_ready_q <= 1'b0;
            if (is_custom) begin
              state     <= ISSUE;
              cnt       <= '0;
              ise_val_q <= 1'b1;
              ise_fn_q  <= {1'b0, bus.dec_instr[14:12], cidx};
            end else begin
              state        <= TRAP;
              trap_valid_q <= 1'b1;
              trap_cause_q <= 2'b01;
            end
          end
        end

        ISSUE: begin
          if (bus.ise_oval) begin
            ise_val_q <= 1'b0;
            wb_data_q <= bus.ise_out;
            wb_rd_q   <= req.instr[11:7];
            // x0 destination: result is dropped, no writeback handshake
            if (req.instr[11:7] == 5'd0) begin
              state       <= IDLE;
              dec_ready_q <= 1'b1;
            end else begin
              state      <= WB;
              wb_valid_q <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            state        <= TRAP;
            ise_val_q    <= 1'b0;
            trap_valid_q <= 1'b1;
            trap_cause_q <= 2'b10;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        WB: begin
          if (bus.wb_ready) begin
            state       <= IDLE;
            wb_valid_q  <= 1'b0;
            dec_ready_q <= 1'b1;
          end
        end

        TRAP: begin
          if (bus.trap_ack) begin
            state        <= IDLE;
            trap_valid_q <= 1'b0;
            dec_ready_q  <= 1'b1;
          end
        end

        default: begin
          state       <= IDLE;
          dec_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.dec_ready  = dec_ready_q;
  assign bus.ise_val    = ise_val_q;
  assign bus.ise_fn     = ise_fn_q;
  assign bus.ise_imm    = req.instr[31:25];
  assign bus.ise_in1    = req.rs1;
  assign bus.ise_in2    = req.rs2;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.trap_valid = trap_valid_q;
  assign bus.trap_cause = trap_cause_q;
  assign bus.trap_instr = req.instr;

`ifdef ISE_ISSUE_PERF_EN
  logic [31:0] perf_issued_q;
  logic [31:0] perf_trap_q;
  logic        enter_issue;
  logic        enter_trap;

  // Mirrors the FSM's entry conditions into ISSUE and TRAP.
  always_comb begin
    enter_issue = 1'b0;
    enter_trap  = 1'b0;
    if (!bus.flush) begin
      if (state == IDLE && accept) begin
        enter_issue = is_custom;
        enter_trap  = !is_custom;
      end else if (state == ISSUE && !bus.ise_oval && cnt == CNT_LAST) begin
        enter_trap = 1'b1;
      end
    end
  end

  always_ff @(posedge ise_clk) begin
    if (!ise_rst) begin
      perf_issued_q <= '0;
      perf_trap_q   <= '0;
    end else begin
      if (enter_issue) perf_issued_q <= perf_issued_q + 32'd1;
      if (enter_trap)  perf_trap_q   <= perf_trap_q + 32'd1;
    end
  end

  assign bus.perf_issued = perf_issued_q;
  assign bus.perf_trap   = perf_trap_q;
`else
  assign bus.perf_issued = '0;
  assign bus.perf_trap   = '0;
`endif

endmodule

// File: doc/ise_issue.md
ISE_ISSUE -- requirements
Module: ise_issue

Interface
REQ-001 Parameter: TIMEOUT, default 4, max cycles ise_val is held awaiting ise_oval (range 1..15).
REQ-002 ise_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 ise_rst  in  1  reset, synchronous, active-low.
REQ-004 dec_valid  in  1  decode stage offers an instruction.
REQ-005 dec_ready  out  1  issuer accepts instruction this cycle.
REQ-006 dec_instr  in  32  instruction word.
REQ-007 dec_rs1, dec_rs2  in  32 each  operand register values.
REQ-008 flush  in  1  pipeline flush; aborts any in-flight operation.
REQ-009 ise_val  out  1  request to ISE ALU.
REQ-010 ise_fn  out  6  {2'b00, funct3, 1'b0}... no: {1'b0, funct3[2:0], custom index[1:0]}.
REQ-011 ise_imm  out  7  funct7 (instr[31:25]).
REQ-012 ise_in1, ise_in2  out  32 each  registered rs1/rs2.
REQ-013 ise_oval  in  1  ISE claims and completes request.
REQ-014 ise_out  in  32  ISE result, valid when ise_oval.
REQ-015 wb_valid  out  1; wb_ready  in  1; wb_rd  out  5; wb_data  out  32  writeback handshake.
REQ-016 trap_valid  out  1; trap_cause  out  2; trap_instr  out  32; trap_ack  in  1.
REQ-017 perf_issued, perf_trap  out  32 each  performance counters.

Function
REQ-018 FSM states IDLE, ISSUE, WB, TRAP; dec_ready=1 only in IDLE.
REQ-019 Accept = dec_valid && dec_ready; instr, rs1, rs2 latched on accept.
REQ-020 Custom opcodes: 0001011->idx 0, 0101011->1, 1011011->2, 1111011->3; accepted custom -> ISSUE, wait counter cleared.
REQ-021 Accepted non-custom opcode -> TRAP, trap_cause=2'b01.
REQ-022 ISSUE: ise_val=1, ise_fn/ise_imm/ise_in1/ise_in2 driven from latched registers, stable throughout.
REQ-023 ISSUE with ise_oval=1: wb_data<=ise_out, wb_rd<=instr[11:7]; next state WB, or IDLE if rd==0 (no wb_valid).
REQ-024 ISSUE without ise_oval: counter increments; at count TIMEOUT-1 without oval -> TRAP, trap_cause=2'b10.
REQ-025 Latency: accept in cycle T, ise_val high T+1, earliest wb_valid T+2.
REQ-026 WB: wb_valid held with wb_data/wb_rd stable until wb_ready; wb_valid && wb_ready -> IDLE; next accept earliest following cycle.
REQ-027 TRAP: trap_valid held, trap_instr = latched instr, until trap_ack -> IDLE.
REQ-028 ise_val, wb_valid, trap_valid never asserted simultaneously.
REQ-029 flush highest priority: any state -> IDLE next cycle; no wb_valid/trap_valid for flushed op; accept in flush cycle suppressed.
REQ-030 ise_oval in non-ISSUE states ignored.
REQ-031 Counters wrap modulo 2^32; perf_issued +1 per transition into ISSUE; perf_trap +1 per transition into TRAP.

Reset
REQ-032 ise_rst=0 at clock edge: state IDLE, counter 0, all outputs 0 except dec_ready=1 from first cycle after reset.
REQ-033 Reset mid-operation discards in-flight op without wb_valid/trap_valid; perf counters cleared.

Configuration
REQ-034 Macro ISE_ISSUE_PERF_EN: defined -> perf_issued/perf_trap implemented per REQ-031.
REQ-035 Macro ISE_ISSUE_PERF_EN undefined -> perf_issued/perf_trap tied to 0, no counter registers.

Verification
REQ-036 Instr 0x0620A05B (custom-2, funct7=3, rd=0, ...) replaced: instr 0x0620A0DB (custom-2, funct7=3, funct3=2, rd=1), model ISE oval at once, out=0xDEADBEEF -> ise_fn=6'b001010, ise_imm=7'h03, wb_valid at T+2, wb_rd=1, wb_data=0xDEADBEEF.
REQ-037 Same instr, model never asserts oval, TIMEOUT=4 -> ise_val high 4 cycles, then trap_valid, trap_cause=2'b10, trap_instr=0x0620A0DB.
REQ-038 Instr 0x00000033 (OP opcode) -> trap_cause=2'b01, ise_val never asserted.
REQ-039 wb_ready low 5 cycles after wb_valid -> wb_data/wb_rd stable, dec_ready=0, returns IDLE after handshake.
REQ-040 flush in second ISSUE cycle -> IDLE next cycle, no wb_valid/trap_valid; perf_issued=1, perf_trap=0 (macro defined), both 0 (undefined).
REQ-041 rd=0 custom instr with oval -> no wb_valid, dec_ready=1 at T+2.
